// File: rtl/cache_refill_ctrl_if.sv
// Cache/memory-facing bundle for cache_refill_ctrl: request, block-fill and word-wide memory beat signals.
// The slave modport is the refill controller's view; master is the cache/memory side.
interface cache_refill_ctrl_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 30,
  parameter int BLOCK_SIZE    = 3
);
  localparam int JUST_DATA = DATA_WIDTH * (2 ** BLOCK_SIZE);

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;

  logic                     fill_valid;
  logic [JUST_DATA-1:0]     fill_block;
  logic [ADDRESS_WIDTH-1:0] fill_addr;
  logic                     wr_done;

  logic                     mem_req;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic                     mem_ack;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, fill_valid, fill_block, fill_addr, wr_done,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, fill_valid, fill_block, fill_addr, wr_done,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Refill controller: fetches a 2**BLOCK_SIZE-word block one memory beat at a time and returns it
// with a one-cycle fill strobe; also forwards single-word write-through stores.
module cache_refill_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 30,
  parameter int BLOCK_SIZE    = 3
) (
  input logic              clk,
  input logic              rst,
  cache_refill_ctrl_if.slave bus
);
  localparam int unsigned WORDS     = 2 ** BLOCK_SIZE;
  localparam int          JUST_DATA = DATA_WIDTH * (2 ** BLOCK_SIZE);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                   state_q, state_d;
  logic [BLOCK_SIZE-1:0]    beat_q, beat_d;
  logic [ADDRESS_WIDTH-1:0] base_q, base_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [ADDRESS_WIDTH-1:0] fill_addr_q, fill_addr_d;
  logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic [JUST_DATA-1:0]     fill_block_q, fill_block_d;
  logic                     req_ready_q, req_ready_d;
  logic                     fill_valid_q, fill_valid_d;
  logic                     wr_done_q, wr_done_d;
  logic                     mem_req_q, mem_req_d;
  logic                     mem_we_q, mem_we_d;

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    base_d       = base_q;
    mem_addr_d   = mem_addr_q;
    fill_addr_d  = fill_addr_q;
    mem_wdata_d  = mem_wdata_q;
    fill_block_d = fill_block_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    fill_valid_d = 1'b0;
    wr_done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          mem_req_d = 1'b1;
          if (bus.req_we) begin
            state_d     = WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = bus.req_addr;
            mem_wdata_d = bus.req_wdata;
          end else begin
            state_d    = READ;
            mem_we_d   = 1'b0;
            beat_d     = '0;
            base_d     = {bus.req_addr[ADDRESS_WIDTH-1:BLOCK_SIZE], {BLOCK_SIZE{1'b0}}};
            mem_addr_d = {bus.req_addr[ADDRESS_WIDTH-1:BLOCK_SIZE], {BLOCK_SIZE{1'b0}}};
          end
        end
      end
      READ: begin
        if (bus.mem_ack) begin
          for (int unsigned i = 0; i < WORDS; i++) begin
            if (beat_q == BLOCK_SIZE'(i)) begin
              fill_block_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.mem_rdata;
            end
          end
          // beat wraps to zero on the last word; base is aligned so base+beat stays in the block
          beat_d = beat_q + 1'b1;
          if (beat_q == '1) begin
            state_d      = DONE;
            mem_req_d    = 1'b0;
            fill_valid_d = 1'b1;
            fill_addr_d  = base_q;
          end else begin
            mem_addr_d = base_q + ADDRESS_WIDTH'(beat_d);
          end
        end
      end
      WRITE: begin
        if (bus.mem_ack) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          wr_done_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      base_q       <= '0;
      mem_addr_q   <= '0;
      fill_addr_q  <= '0;
      mem_wdata_q  <= '0;
      fill_block_q <= '0;
      req_ready_q  <= 1'b1;
      fill_valid_q <= 1'b0;
      wr_done_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      base_q       <= base_d;
      mem_addr_q   <= mem_addr_d;
      fill_addr_q  <= fill_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      fill_block_q <= fill_block_d;
      req_ready_q  <= req_ready_d;
      fill_valid_q <= fill_valid_d;
      wr_done_q    <= wr_done_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.fill_valid = fill_valid_q;
  assign bus.fill_block = fill_block_q;
  assign bus.fill_addr  = fill_addr_q;
  assign bus.wr_done    = wr_done_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: transaction-level model compared every cycle, plus directed literal checks.
module tb_cache_refill_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_refill_ctrl_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(30), .BLOCK_SIZE(3)) bus ();

  cache_refill_ctrl #(.DATA_WIDTH(32), .ADDRESS_WIDTH(30), .BLOCK_SIZE(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;
  int fill_cnt = 0;
  int wr_cnt   = 0;

  localparam logic [255:0] BLK_A =
    256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [255:0] blk(input logic [31:0] t);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = t + 32'(i);
    return r;
  endfunction

  // Memory responder: acks after ack_delay waiting cycles per beat; data = tag + word offset.
  int          ack_delay = 0;
  logic        force_ack = 1'b0;
  logic [31:0] tag = '0;
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_req === 1'b1 && !force_ack) begin
        if (wait_cnt >= ack_delay) begin
          bus.mem_ack = 1'b1;
          wait_cnt = 0;
        end else begin
          bus.mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        bus.mem_ack = force_ack;
        wait_cnt = 0;
      end
      bus.mem_rdata = bus.mem_ack ? tag + 32'(bus.mem_addr[2:0]) : 32'hBAD0_BAD0;
    end
  end

  // Transaction-level model: what is in flight, how many words returned, which pulse is due.
  int           m_kind = 0;  // 0 none, 1 refill, 2 store
  int           m_acks = 0;
  logic [29:0]  m_base = '0, m_waddr = '0, m_fill_addr = '0;
  logic [31:0]  m_wdata = '0;
  logic [255:0] m_block = '0;
  bit           m_pf = 1'b0, m_pw = 1'b0, m_was = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_kind = 0; m_acks = 0; m_pf = 1'b0; m_pw = 1'b0; m_block = '0;
    end else begin
      m_was = m_pf | m_pw;
      m_pf = 1'b0;
      m_pw = 1'b0;
      if (m_kind == 0) begin
        if (!m_was && bus.req_valid) begin
          if (bus.req_we) begin
            m_kind = 2; m_waddr = bus.req_addr; m_wdata = bus.req_wdata;
          end else begin
            m_kind = 1; m_acks = 0; m_base = bus.req_addr & ~30'h7;
          end
        end
      end else if (m_kind == 1) begin
        if (bus.mem_ack) begin
          m_block[m_acks*32 +: 32] = bus.mem_rdata;
          m_acks++;
          if (m_acks == 8) begin
            m_kind = 0; m_pf = 1'b1; m_fill_addr = m_base;
          end
        end
      end else if (bus.mem_ack) begin
        m_kind = 0; m_pw = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", bus.req_ready, (m_kind == 0 && !m_pf && !m_pw));
      chk("fill_valid", bus.fill_valid, m_pf);
      chk("wr_done", bus.wr_done, m_pw);
      chk("mem_req", bus.mem_req, (m_kind != 0));
      chk("mem_we", bus.mem_we, (m_kind == 2));
      if (m_kind == 1) chk("mem_addr_rd", bus.mem_addr, m_base + 30'(m_acks));
      if (m_kind == 2) begin
        chk("mem_addr_wr", bus.mem_addr, m_waddr);
        chk("mem_wdata", bus.mem_wdata, m_wdata);
      end
      if (m_pf) begin
        chk("fill_addr", bus.fill_addr, m_fill_addr);
        chk("fill_block", bus.fill_block, m_block);
      end
      if (bus.fill_valid === 1'b1) fill_cnt++;
      if (bus.wr_done === 1'b1) wr_cnt++;
    end
  end

  // Called at a negedge; returns the pre-edge cycle index of the accepting edge.
  task automatic start_req(input bit we, input logic [29:0] addr, input logic [31:0] wd, output int a);
    int n;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 1'b0, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(posedge clk);
    a = cyc;
  endtask

  task automatic wait_fill(input string nm, input int a, input int exp_at,
                           input logic [29:0] exp_addr, input logic [255:0] exp_blk);
    int at;
    at = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.fill_valid === 1'b1) begin
        at = cyc - a;
        break;
      end
    end
    chk({nm, "_fill_cycle"}, 256'(at), 256'(exp_at));
    chk({nm, "_fill_addr"}, bus.fill_addr, exp_addr);
    chk({nm, "_fill_block"}, bus.fill_block, exp_blk);
    @(negedge clk);
    chk({nm, "_fill_width"}, bus.fill_valid, 1'b0);
  endtask

  initial begin
    int a;
    int at;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_fill_valid", bus.fill_valid, 1'b0);
    chk("rst_wr_done", bus.wr_done, 1'b0);
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 30'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_fill_block", bus.fill_block, 256'h0);
    chk("rst_fill_addr", bus.fill_addr, 30'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Refill, ack always high.
    tag = 32'hA0; ack_delay = 0;
    start_req(1'b0, 30'h123, 32'h0, a);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) bus.req_valid = 1'b0;
      chk("t1_mem_addr", bus.mem_addr, 30'h120 + 30'(i));
    end
    wait_fill("t1", a, 9, 30'h120, BLK_A);

    // Refill, 3 wait cycles per beat.
    ack_delay = 3;
    start_req(1'b0, 30'h123, 32'h0, a);
    @(negedge clk); bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t2_wait_addr", bus.mem_addr, 30'h120);
    chk("t2_wait_req", bus.mem_req, 1'b1);
    wait_fill("t2", a, 33, 30'h120, BLK_A);

    // Store with 2 wait cycles.
    ack_delay = 2;
    start_req(1'b1, 30'h55, 32'hDEADBEEF, a);
    @(negedge clk); bus.req_valid = 1'b0;
    chk("t3_mem_we", bus.mem_we, 1'b1);
    chk("t3_mem_addr", bus.mem_addr, 30'h55);
    chk("t3_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    at = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.wr_done === 1'b1) begin
        at = cyc - a;
        break;
      end
    end
    chk("t3_wr_cycle", 256'(at), 256'(4));
    @(negedge clk);
    chk("t3_wr_width", bus.wr_done, 1'b0);

    // Reset after the 4th beat, then a clean refill.
    tag = 32'h30; ack_delay = 0;
    start_req(1'b0, 30'h040, 32'h0, a);
    @(negedge clk); bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_mem_req", bus.mem_req, 1'b0);
    chk("t4_req_ready", bus.req_ready, 1'b1);
    chk("t4_fill_valid", bus.fill_valid, 1'b0);
    chk("t4_mem_addr", bus.mem_addr, 30'h0);
    rst = 1'b0;
    tag = 32'hC0;
    start_req(1'b0, 30'h200, 32'h0, a);
    @(negedge clk); bus.req_valid = 1'b0;
    wait_fill("t4", a, 9, 30'h200, blk(32'hC0));

    // Stray acks while idle, then a request held high across a refill.
    tag = 32'hE0;
    force_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_stray_mem_req", bus.mem_req, 1'b0);
    chk("t5_stray_ready", bus.req_ready, 1'b1);
    chk("t5_stray_block", bus.fill_block, blk(32'hC0));
    force_ack = 1'b0;
    @(negedge clk);
    start_req(1'b0, 30'h305, 32'h0, a);
    wait_fill("t5a", a, 9, 30'h300, blk(32'hE0));
    @(negedge clk); bus.req_valid = 1'b0;
    wait_fill("t5b", a, 19, 30'h300, blk(32'hE0));

    repeat (3) @(negedge clk);
    chk("fill_count", 256'(fill_cnt), 256'(5));
    chk("wr_count", 256'(wr_cnt), 256'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, bad=%0d", bad);
    $fatal(1, "watchdog");
  end
endmodule
